// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM between two req/ack requesters.
// Each access holds the DRAM bus for LATENCY cycles, then acks for one cycle.
module dram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dram_arbiter: LATENCY must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                grant;

  // On a tie the port that was not granted last wins; a lone request always wins.
  assign grant = (m0_req && m1_req) ? ~last_q : m1_req;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = grant;
          last_d  = grant;
          we_d    = grant ? m1_we    : m0_we;
          addr_d  = grant ? m1_addr  : m0_addr;
          wdata_d = grant ? m1_wdata : m0_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (owner_q) begin
            m1_ack_d = 1'b1;
            if (!we_q) m1_rdata_d = mem_rdata;
          end else begin
            m0_ack_d = 1'b1;
            if (!we_q) m0_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Address and write data hold their last values outside ACCESS to avoid bus toggling.
  assign mem_cs    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: three builds (LATENCY 2, 1, 15), each with a
// small word-addressed RAM model behind the DRAM port.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        m0_req [3], m0_we [3], m0_ack [3];
  logic [31:0] m0_addr [3], m0_wdata [3], m0_rdata [3];
  logic        m1_req [3], m1_we [3], m1_ack [3];
  logic [31:0] m1_addr [3], m1_wdata [3], m1_rdata [3];
  logic        mem_cs [3], mem_we [3], busy [3];
  logic [31:0] mem_addr [3], mem_wdata [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] ram [64];
    logic [31:0] rd;
    assign rd = ram[mem_addr[g][7:2]];
    always @(posedge clk) if (mem_cs[g] && mem_we[g]) ram[mem_addr[g][7:2]] <= mem_wdata[g];

    dram_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0_req   (m0_req[g]),
      .m0_we    (m0_we[g]),
      .m0_addr  (m0_addr[g]),
      .m0_wdata (m0_wdata[g]),
      .m0_ack   (m0_ack[g]),
      .m0_rdata (m0_rdata[g]),
      .m1_req   (m1_req[g]),
      .m1_we    (m1_we[g]),
      .m1_addr  (m1_addr[g]),
      .m1_wdata (m1_wdata[g]),
      .m1_ack   (m1_ack[g]),
      .m1_rdata (m1_rdata[g]),
      .mem_cs   (mem_cs[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(rd),
      .busy     (busy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One access on instance k. Returns edges from request to ack, cycles with
  // mem_we high, whether the other port acked, and the address on the bus in
  // the last ACCESS cycle. Inputs are scrambled after the grant edge.
  task automatic do_access(input int k, input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int we_cycles,
                           output bit other_ack, output logic [31:0] addr_seen);
    bit got;
    lat = 0; we_cycles = 0; other_ack = 1'b0; addr_seen = '0; got = 1'b0;
    if (!port) begin
      m0_we[k] = we; m0_addr[k] = addr; m0_wdata[k] = wdata; m0_req[k] = 1'b1;
    end else begin
      m1_we[k] = we; m1_addr[k] = addr; m1_wdata[k] = wdata; m1_req[k] = 1'b1;
    end
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (mem_we[k]) we_cycles++;
      if (mem_cs[k]) addr_seen = mem_addr[k];
      if (port ? m0_ack[k] : m1_ack[k]) other_ack = 1'b1;
      if (port ? m1_ack[k] : m0_ack[k]) got = 1'b1;
      if (lat == 1) begin
        if (!port) begin m0_addr[k] = ~addr; m0_wdata[k] = ~wdata; m0_we[k] = ~we; end
        else       begin m1_addr[k] = ~addr; m1_wdata[k] = ~wdata; m1_we[k] = ~we; end
      end
    end
    if (!port) m0_req[k] = 1'b0;
    else       m1_req[k] = 1'b0;
  endtask

  // Both ports request reads in the same cycle on instance 0; each drops its
  // request on its own ack. Reports which acked first and t(m1) - t(m0).
  task automatic tie_pair(output int first, output int gap);
    int t, t0, t1;
    t = 0; t0 = -100; t1 = -100; first = -1;
    m0_we[0] = 1'b0; m0_addr[0] = 32'h10; m0_req[0] = 1'b1;
    m1_we[0] = 1'b0; m1_addr[0] = 32'h20; m1_req[0] = 1'b1;
    while ((t0 < 0 || t1 < 0) && t < 40) begin
      tick();
      t++;
      if (m0_ack[0]) begin t0 = t; m0_req[0] = 1'b0; if (first < 0) first = 0; end
      if (m1_ack[0]) begin t1 = t; m1_req[0] = 1'b0; if (first < 0) first = 1; end
    end
    m0_req[0] = 1'b0;
    m1_req[0] = 1'b0;
    gap = t1 - t0;
  endtask

  initial begin
    int lat, wec, first, gap, acks;
    bit oth;
    logic [31:0] as;

    for (int i = 0; i < 3; i++) begin
      m0_req[i] = 0; m0_we[i] = 0; m0_addr[i] = 0; m0_wdata[i] = 0;
      m1_req[i] = 0; m1_we[i] = 0; m1_addr[i] = 0; m1_wdata[i] = 0;
    end
    do_reset();

    // Reset state
    check("rst_busy",      busy[0],      0);
    check("rst_mem_cs",    mem_cs[0],    0);
    check("rst_mem_we",    mem_we[0],    0);
    check("rst_mem_addr",  mem_addr[0],  0);
    check("rst_mem_wdata", mem_wdata[0], 0);
    check("rst_acks",      {m0_ack[0], m1_ack[0]}, 0);
    check("rst_rdata",     {m0_rdata[0], m1_rdata[0]}, 0);

    // Test 1: m0 write, LATENCY=2
    do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, wec, oth, as);
    check("t1_lat",      lat, 3);
    check("t1_we_cyc",   wec, 2);
    check("t1_no_m1ack", oth, 0);
    check("t1_addr",     as,  32'h10);
    tick();
    check("t1_idle_cs",    mem_cs[0],    0);
    check("t1_hold_addr",  mem_addr[0],  32'h10);
    check("t1_hold_wdata", mem_wdata[0], 32'hDEADBEEF);

    // Test 2: m0 read back
    do_access(0, 0, 0, 32'h10, 32'h0, lat, wec, oth, as);
    check("t2_lat",   lat, 3);
    check("t2_we_cyc", wec, 0);
    check("t2_rdata", m0_rdata[0], 32'hDEADBEEF);
    tick();

    // Test 3: four back-to-back tied pairs after reset; grants alternate 0,1,0,1,...
    do_reset();
    for (int p = 0; p < 4; p++) begin
      tie_pair(first, gap);
      check($sformatf("t3_first_%0d", p), first, 0);
      check($sformatf("t3_gap_%0d", p),   gap,   4);
    end
    tick();

    // Test 4: lone m1 writes always win
    for (int r = 0; r < 3; r++) begin
      do_access(0, 1, 1, 32'h20, 32'h12345678, lat, wec, oth, as);
      check($sformatf("t4_lat_%0d", r),  lat, 3);
      check($sformatf("t4_nom0_%0d", r), oth, 0);
      tick();
    end
    // Lone m0 grant makes m0 last, so the next tie goes to m1
    do_access(0, 0, 0, 32'h20, 32'h0, lat, wec, oth, as);
    check("t4_m0_rd", m0_rdata[0], 32'h12345678);
    tick();
    tie_pair(first, gap);
    check("t4_tie_first", first, 1);
    check("t4_tie_gap",   gap,   -4);
    tick();

    // Test 5: reset during an m0 write
    m0_we[0] = 1'b1; m0_addr[0] = 32'h30; m0_wdata[0] = 32'hCAFEF00D; m0_req[0] = 1'b1;
    tick();
    check("t5_busy_acc", busy[0],   1);
    check("t5_cs_acc",   mem_cs[0], 1);
    check("t5_we_acc",   mem_we[0], 1);
    rst_n = 1'b0;
    tick();
    check("t5_cs",    mem_cs[0],   0);
    check("t5_we",    mem_we[0],   0);
    check("t5_busy",  busy[0],     0);
    check("t5_ack",   m0_ack[0],   0);
    check("t5_addr",  mem_addr[0], 0);
    check("t5_rdata", m0_rdata[0], 0);
    m0_req[0] = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (m0_ack[0]) acks++;
    end
    check("t5_no_late_ack", acks, 0);
    do_access(0, 1, 0, 32'h20, 32'h0, lat, wec, oth, as);
    check("t5_m1_lat",   lat, 3);
    check("t5_m1_rdata", m1_rdata[0], 32'h12345678);
    tick();

    // Test 6a: LATENCY=1
    do_access(1, 0, 1, 32'h40, 32'hA5A5A5A5, lat, wec, oth, as);
    check("t6a_wr_lat", lat, 2);
    check("t6a_we_cyc", wec, 1);
    tick();
    do_access(1, 0, 0, 32'h40, 32'h0, lat, wec, oth, as);
    check("t6a_rd_lat", lat, 2);
    check("t6a_rdata",  m0_rdata[1], 32'hA5A5A5A5);
    tick();
    do_access(1, 1, 1, 32'h44, 32'h11112222, lat, wec, oth, as);
    tick();
    do_access(1, 1, 0, 32'h44, 32'h0, lat, wec, oth, as);
    check("t6a_m1_rdata", m1_rdata[1], 32'h11112222);
    check("t6a_m0_hold",  m0_rdata[1], 32'hA5A5A5A5);
    tick();

    // Test 6b: LATENCY=15
    do_access(2, 0, 1, 32'h80, 32'h0F0F1234, lat, wec, oth, as);
    check("t6b_wr_lat", lat, 16);
    check("t6b_we_cyc", wec, 15);
    tick();
    do_access(2, 0, 0, 32'h80, 32'h0, lat, wec, oth, as);
    check("t6b_rd_lat", lat, 16);
    check("t6b_rdata",  m0_rdata[2], 32'h0F0F1234);
    tick();
    do_access(2, 1, 0, 32'h80, 32'h0, lat, wec, oth, as);
    check("t6b_m1_rdata", m1_rdata[2], 32'h0F0F1234);
    do_access(2, 1, 1, 32'h84, 32'h55AA55AA, lat, wec, oth, as);
    check("t6b_m0_hold",  m0_rdata[2], 32'h0F0F1234);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
